// File: rtl/sys_reg_commit_ctrl_if.sv
// -----------------------------------------------------------------------------
// sys_reg_commit_ctrl_if
// Purpose : bundles the execute-stage system-register request, the pipeline
//           drain status, the MMU flush handshake, the fetch reload handshake
//           and the committed architectural registers into one interface.
// Modports:
//   slave  - the commit controller (receives requests, drives responses)
//   master - the surrounding environment (execute / fetch / MMU side)
// Signals :
//   iVALID, iCTRL_IDT_VALID, iCTRL_PDT_VALID, iCTRL_PSR_VALID   request + kind
//   iDATA[31:0], iRELOAD_ADDR[31:0]                             payload
//   iPIPE_EMPTY                                                 drain status
//   oTLB_FLUSH_REQ / iTLB_FLUSH_ACK                             MMU flush
//   oRELOAD_VALID / oRELOAD_ADDR[31:0] / iRELOAD_ACK            fetch redirect
//   oBUSY, oERROR, oPSR, oIDTR, oPDTR                           status / regs
// -----------------------------------------------------------------------------
interface sys_reg_commit_ctrl_if;
    logic        iVALID;
    logic        oBUSY;
    logic        iCTRL_IDT_VALID;
    logic        iCTRL_PDT_VALID;
    logic        iCTRL_PSR_VALID;
    logic [31:0] iDATA;
    logic [31:0] iRELOAD_ADDR;
    logic        iPIPE_EMPTY;
    logic        oTLB_FLUSH_REQ;
    logic        iTLB_FLUSH_ACK;
    logic        oRELOAD_VALID;
    logic [31:0] oRELOAD_ADDR;
    logic        iRELOAD_ACK;
    logic [31:0] oPSR;
    logic [31:0] oIDTR;
    logic [31:0] oPDTR;
    logic        oERROR;

    modport slave (
        input  iVALID, iCTRL_IDT_VALID, iCTRL_PDT_VALID, iCTRL_PSR_VALID,
        input  iDATA, iRELOAD_ADDR, iPIPE_EMPTY, iTLB_FLUSH_ACK, iRELOAD_ACK,
        output oBUSY, oTLB_FLUSH_REQ, oRELOAD_VALID, oRELOAD_ADDR,
        output oPSR, oIDTR, oPDTR, oERROR
    );

    modport master (
        output iVALID, iCTRL_IDT_VALID, iCTRL_PDT_VALID, iCTRL_PSR_VALID,
        output iDATA, iRELOAD_ADDR, iPIPE_EMPTY, iTLB_FLUSH_ACK, iRELOAD_ACK,
        input  oBUSY, oTLB_FLUSH_REQ, oRELOAD_VALID, oRELOAD_ADDR,
        input  oPSR, oIDTR, oPDTR, oERROR
    );
endinterface

// File: rtl/sys_reg_commit_ctrl.sv
// -----------------------------------------------------------------------------
// sys_reg_commit_ctrl
// Purpose : consumer side of the execute-stage system-register interface.
//           Accepts an IDTR / PDTR / PSR write, waits for the pipeline to
//           drain, commits the architectural register, requests a TLB flush
//           when translation state changes, then redirects fetch to the saved
//           PC. Owns the IDTR, PDTR and PSR registers.
// Ports   :
//   iCLOCK       in  clock
//   iRESET_SYNC  in  synchronous active-high reset (aborts any operation)
//   bus          sys_reg_commit_ctrl_if.slave (request, handshakes, registers)
// Parameters:
//   P_PSR_RESET / P_IDT_RESET / P_PDT_RESET  register reset values
//   P_TIMEOUT    watchdog limit in cycles
// Configuration:
//   SYS_REG_WATCHDOG_EN  when defined, a 16-bit watchdog bounds the DRAIN,
//                        TLB_WAIT and RELOAD waits; on expiry oERROR is set
//                        (sticky until reset) and the FSM returns to IDLE.
//                        When undefined, waits are unbounded, oERROR is 0.
// -----------------------------------------------------------------------------
module sys_reg_commit_ctrl #(
    parameter logic [31:0] P_PSR_RESET = 32'h0000_0000,
    parameter logic [31:0] P_IDT_RESET = 32'h0000_0000,
    parameter logic [31:0] P_PDT_RESET = 32'h0000_0000,
    parameter int unsigned P_TIMEOUT   = 1024
) (
    input  logic                  iCLOCK,
    input  logic                  iRESET_SYNC,
    sys_reg_commit_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_COMMIT   = 3'd2,
        ST_TLB_WAIT = 3'd3,
        ST_RELOAD   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        KIND_IDT = 2'd0,
        KIND_PDT = 2'd1,
        KIND_PSR = 2'd2
    } kind_e;

    // Illegal multi-flag requests resolve PSR > PDT > IDT.
    function automatic kind_e sel_kind(input logic psr_v, input logic pdt_v);
        kind_e k;
        if (psr_v) begin
            k = KIND_PSR;
        end else if (pdt_v) begin
            k = KIND_PDT;
        end else begin
            k = KIND_IDT;
        end
        return k;
    endfunction

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [31:0] data_q, data_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] psr_q, psr_d;
    logic [31:0] idtr_q, idtr_d;
    logic [31:0] pdtr_q, pdtr_d;
    logic        busy_q, busy_d;
    logic        tlb_req_q, tlb_req_d;
    logic        reload_valid_q, reload_valid_d;
    logic [31:0] reload_addr_q, reload_addr_d;
    logic        any_flag_s;
    logic        flush_needed_s;

`ifdef SYS_REG_WATCHDOG_EN
    localparam logic [15:0] LP_WD_LAST = 16'(P_TIMEOUT - 32'd1);
    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        error_q, error_d;
    logic        wd_waiting_s;
`else
    logic        unused_timeout_s;
    assign unused_timeout_s = ^(32'(P_TIMEOUT));
`endif

    assign any_flag_s = bus.iCTRL_IDT_VALID | bus.iCTRL_PDT_VALID | bus.iCTRL_PSR_VALID;

    // Next-state, datapath capture, commit and registered-output decode.
    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        data_d         = data_q;
        pc_d           = pc_q;
        psr_d          = psr_q;
        idtr_d         = idtr_q;
        pdtr_d         = pdtr_q;
        reload_addr_d  = reload_addr_q;
        flush_needed_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.iVALID && any_flag_s) begin
                    state_d = ST_DRAIN;
                    kind_d  = sel_kind(bus.iCTRL_PSR_VALID, bus.iCTRL_PDT_VALID);
                    data_d  = bus.iDATA;
                    pc_d    = bus.iRELOAD_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (bus.iPIPE_EMPTY) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_COMMIT: begin
                case (kind_q)
                    KIND_PSR: begin
                        psr_d = data_q;
                        // Only an MMU-mode change invalidates translations.
                        flush_needed_s = (data_q[1:0] != psr_q[1:0]);
                    end
                    KIND_PDT: begin
                        pdtr_d         = data_q;
                        flush_needed_s = 1'b1;
                    end
                    KIND_IDT: begin
                        idtr_d = data_q;
                    end
                    default: begin
                        flush_needed_s = 1'b0;
                    end
                endcase
                if (flush_needed_s) begin
                    state_d = ST_TLB_WAIT;
                end else begin
                    state_d = ST_RELOAD;
                end
            end
            ST_TLB_WAIT: begin
                if (bus.iTLB_FLUSH_ACK) begin
                    state_d = ST_RELOAD;
                end else begin
                    state_d = ST_TLB_WAIT;
                end
            end
            ST_RELOAD: begin
                if (bus.iRELOAD_ACK) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef SYS_REG_WATCHDOG_EN
        wd_cnt_d     = wd_cnt_q;
        error_d      = error_q;
        wd_waiting_s = (state_q == ST_DRAIN) || (state_q == ST_TLB_WAIT) ||
                       (state_q == ST_RELOAD);
        // A legal transition always wins over expiry in the same cycle.
        if (state_d != state_q) begin
            wd_cnt_d = 16'd0;
        end else if (wd_waiting_s) begin
            if (wd_cnt_q == LP_WD_LAST) begin
                state_d  = ST_IDLE;
                error_d  = 1'b1;
                wd_cnt_d = 16'd0;
            end else begin
                wd_cnt_d = wd_cnt_q + 16'd1;
            end
        end else begin
            wd_cnt_d = 16'd0;
        end
`endif

        busy_d         = (state_d != ST_IDLE);
        tlb_req_d      = (state_d == ST_TLB_WAIT);
        reload_valid_d = (state_d == ST_RELOAD);
        // Load the redirect PC only on RELOAD entry so it is stable while valid.
        if ((state_d == ST_RELOAD) && (state_q != ST_RELOAD)) begin
            reload_addr_d = pc_q;
        end else begin
            reload_addr_d = reload_addr_q;
        end
    end

    // State, captured request and architectural registers with sync reset.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q        <= ST_IDLE;
            kind_q         <= KIND_IDT;
            data_q         <= 32'h0000_0000;
            pc_q           <= 32'h0000_0000;
            psr_q          <= P_PSR_RESET;
            idtr_q         <= P_IDT_RESET;
            pdtr_q         <= P_PDT_RESET;
            busy_q         <= 1'b0;
            tlb_req_q      <= 1'b0;
            reload_valid_q <= 1'b0;
            reload_addr_q  <= 32'h0000_0000;
        end else begin
            state_q        <= state_d;
            kind_q         <= kind_d;
            data_q         <= data_d;
            pc_q           <= pc_d;
            psr_q          <= psr_d;
            idtr_q         <= idtr_d;
            pdtr_q         <= pdtr_d;
            busy_q         <= busy_d;
            tlb_req_q      <= tlb_req_d;
            reload_valid_q <= reload_valid_d;
            reload_addr_q  <= reload_addr_d;
        end
    end

`ifdef SYS_REG_WATCHDOG_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            wd_cnt_q <= 16'd0;
            error_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            error_q  <= error_d;
        end
    end

    assign bus.oERROR = error_q;
`else
    assign bus.oERROR = 1'b0;
`endif

    assign bus.oBUSY          = busy_q;
    assign bus.oTLB_FLUSH_REQ = tlb_req_q;
    assign bus.oRELOAD_VALID  = reload_valid_q;
    assign bus.oRELOAD_ADDR   = reload_addr_q;
    assign bus.oPSR           = psr_q;
    assign bus.oIDTR          = idtr_q;
    assign bus.oPDTR          = pdtr_q;

endmodule

// File: tb/tb_sys_reg_commit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sys_reg_commit_ctrl
// Directed stimulus with a scoreboard: each issued request pushes its expected
// reload address, register image and flush flag; a monitor pops and compares
// whenever the DUT raises oRELOAD_VALID. Watchdog scenario runs only when
// SYS_REG_WATCHDOG_EN is defined (P_TIMEOUT = 16 in that build).
// -----------------------------------------------------------------------------
module tb_sys_reg_commit_ctrl;

`ifdef SYS_REG_WATCHDOG_EN
    localparam int unsigned LP_TIMEOUT = 16;
`else
    localparam int unsigned LP_TIMEOUT = 1024;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] psr;
        logic [31:0] idtr;
        logic [31:0] pdtr;
        logic        flush;
    } exp_t;

    logic clk;
    logic rst;
    logic tlb_ack_en;
    logic rel_ack_en;
    logic stray;
    logic mon_prev_rv;
    logic mon_flush_seen;
    exp_t exp_q[$];
    int   checks;
    int   errors;

    sys_reg_commit_ctrl_if bus ();

    sys_reg_commit_ctrl #(
        .P_PSR_RESET (32'h0000_0000),
        .P_IDT_RESET (32'h0000_0000),
        .P_PDT_RESET (32'h0000_0000),
        .P_TIMEOUT   (LP_TIMEOUT)
    ) dut (
        .iCLOCK      (clk),
        .iRESET_SYNC (rst),
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic [31:0] psr,
                            input logic [31:0] idtr, input logic [31:0] pdtr,
                            input logic flush);
        exp_t e;
        e.addr  = addr;
        e.psr   = psr;
        e.idtr  = idtr;
        e.pdtr  = pdtr;
        e.flush = flush;
        exp_q.push_back(e);
    endtask

    // Present a request for one cycle; returns at the negedge after the accept edge.
    task automatic issue(input logic psr_v, input logic pdt_v, input logic idt_v,
                         input logic [31:0] data, input logic [31:0] pc);
        @(negedge clk);
        bus.iVALID          = 1'b1;
        bus.iCTRL_PSR_VALID = psr_v;
        bus.iCTRL_PDT_VALID = pdt_v;
        bus.iCTRL_IDT_VALID = idt_v;
        bus.iDATA           = data;
        bus.iRELOAD_ADDR    = pc;
        @(negedge clk);
        bus.iVALID          = 1'b0;
        bus.iCTRL_PSR_VALID = 1'b0;
        bus.iCTRL_PDT_VALID = 1'b0;
        bus.iCTRL_IDT_VALID = 1'b0;
    endtask

    // Bounded wait for oBUSY to drop; counts negedges spent busy.
    task automatic wait_idle(input string name, output int busy_cycles);
        busy_cycles = 0;
        while (bus.oBUSY && (busy_cycles < 200)) begin
            busy_cycles++;
            @(negedge clk);
        end
        if (bus.oBUSY) begin
            checks++;
            errors++;
            $display("FAIL %s idle_timeout actual=busy expected=idle", name);
        end
    endtask

    // Ack responder: zero-wait acks while enabled, plus optional stray pulses.
    initial begin
        forever begin
            @(negedge clk);
            bus.iTLB_FLUSH_ACK = (bus.oTLB_FLUSH_REQ & tlb_ack_en) | stray;
            bus.iRELOAD_ACK    = (bus.oRELOAD_VALID & rel_ack_en) | stray;
        end
    end

    // Monitor: compare the scoreboard head on every rising oRELOAD_VALID.
    initial begin
        exp_t e;
        mon_prev_rv    = 1'b0;
        mon_flush_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_prev_rv    = 1'b0;
                mon_flush_seen = 1'b0;
            end else begin
                if (bus.oTLB_FLUSH_REQ) mon_flush_seen = 1'b1;
                if (bus.oRELOAD_VALID && !mon_prev_rv) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_reload actual=%h expected=none", bus.oRELOAD_ADDR);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_reload_addr", bus.oRELOAD_ADDR, e.addr);
                        chk("sb_psr", bus.oPSR, e.psr);
                        chk("sb_idtr", bus.oIDTR, e.idtr);
                        chk("sb_pdtr", bus.oPDTR, e.pdtr);
                        chk("sb_flush", {31'd0, mon_flush_seen}, {31'd0, e.flush});
                    end
                    mon_flush_seen = 1'b0;
                end
                mon_prev_rv = bus.oRELOAD_VALID;
            end
        end
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        checks              = 0;
        errors              = 0;
        tlb_ack_en          = 1'b1;
        rel_ack_en          = 1'b1;
        stray               = 1'b0;
        rst                 = 1'b1;
        bus.iVALID          = 1'b0;
        bus.iCTRL_IDT_VALID = 1'b0;
        bus.iCTRL_PDT_VALID = 1'b0;
        bus.iCTRL_PSR_VALID = 1'b0;
        bus.iDATA           = 32'h0;
        bus.iRELOAD_ADDR    = 32'h0;
        bus.iPIPE_EMPTY     = 1'b1;
        bus.iTLB_FLUSH_ACK  = 1'b0;
        bus.iRELOAD_ACK     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_busy", {31'd0, bus.oBUSY}, 32'd0);
        chk("rst_tlb_req", {31'd0, bus.oTLB_FLUSH_REQ}, 32'd0);
        chk("rst_reload_valid", {31'd0, bus.oRELOAD_VALID}, 32'd0);
        chk("rst_reload_addr", bus.oRELOAD_ADDR, 32'h0);
        chk("rst_psr", bus.oPSR, 32'h0);
        chk("rst_idtr", bus.oIDTR, 32'h0);
        chk("rst_pdtr", bus.oPDTR, 32'h0);
        chk("rst_error", {31'd0, bus.oERROR}, 32'd0);

        // 1: IDT write, minimum occupancy (DRAIN, COMMIT, RELOAD busy)
        push_exp(32'h100, 32'h0, 32'h8000, 32'h0, 1'b0);
        issue(1'b0, 1'b0, 1'b1, 32'h0000_8000, 32'h100);
        chk("t1_busy_after_accept", {31'd0, bus.oBUSY}, 32'd1);
        wait_idle("t1", n);
        chk("t1_busy_cycles", n, 32'd3);

        // 2: PDT write, pipe not empty for 5 cycles
        bus.iPIPE_EMPTY = 1'b0;
        push_exp(32'h200, 32'h0, 32'h8000, 32'h0001_0000, 1'b1);
        issue(1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'h200);
        for (int i = 0; i < 5; i++) begin
            chk("t2_drain_busy", {31'd0, bus.oBUSY}, 32'd1);
            chk("t2_drain_no_flush", {31'd0, bus.oTLB_FLUSH_REQ}, 32'd0);
            chk("t2_drain_no_reload", {31'd0, bus.oRELOAD_VALID}, 32'd0);
            @(negedge clk);
        end
        bus.iPIPE_EMPTY = 1'b1;
        wait_idle("t2", n);

        // 3: PSR mode change flushes; same mode does not
        push_exp(32'h300, 32'h1, 32'h8000, 32'h0001_0000, 1'b1);
        issue(1'b1, 1'b0, 1'b0, 32'h1, 32'h300);
        wait_idle("t3a", n);
        push_exp(32'h304, 32'h61, 32'h8000, 32'h0001_0000, 1'b0);
        issue(1'b1, 1'b0, 1'b0, 32'h61, 32'h304);
        wait_idle("t3b", n);

        // 4: all flags -> PSR only; request while busy is dropped
        bus.iPIPE_EMPTY = 1'b0;
        push_exp(32'h400, 32'h5, 32'h8000, 32'h0001_0000, 1'b0);
        issue(1'b1, 1'b1, 1'b1, 32'h5, 32'h400);
        bus.iVALID          = 1'b1;
        bus.iCTRL_IDT_VALID = 1'b1;
        bus.iDATA           = 32'hDEAD_BEEF;
        bus.iRELOAD_ADDR    = 32'h999;
        @(negedge clk);
        bus.iVALID          = 1'b0;
        bus.iCTRL_IDT_VALID = 1'b0;
        chk("t4_still_busy", {31'd0, bus.oBUSY}, 32'd1);
        bus.iPIPE_EMPTY = 1'b1;
        wait_idle("t4", n);
        repeat (3) @(negedge clk);
        chk("t4_idtr_kept", bus.oIDTR, 32'h8000);
        chk("t4_no_second_op", {31'd0, bus.oBUSY}, 32'd0);

        // iVALID without a flag is ignored
        bus.iVALID = 1'b1;
        @(negedge clk);
        bus.iVALID = 1'b0;
        chk("noflag_idle", {31'd0, bus.oBUSY}, 32'd0);

        // Stray acks while idle are ignored
        stray = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stray = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_busy", {31'd0, bus.oBUSY}, 32'd0);
        chk("stray_reload", {31'd0, bus.oRELOAD_VALID}, 32'd0);
        chk("stray_psr", bus.oPSR, 32'h5);

        // 5: reset while waiting for the TLB flush
        tlb_ack_en = 1'b0;
        issue(1'b0, 1'b1, 1'b0, 32'h0002_0000, 32'h500);
        n = 0;
        while (!bus.oTLB_FLUSH_REQ && (n < 50)) begin
            n++;
            @(negedge clk);
        end
        chk("t5_in_tlb_wait", {31'd0, bus.oTLB_FLUSH_REQ}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_busy", {31'd0, bus.oBUSY}, 32'd0);
        chk("t5_tlb_req", {31'd0, bus.oTLB_FLUSH_REQ}, 32'd0);
        chk("t5_reload_valid", {31'd0, bus.oRELOAD_VALID}, 32'd0);
        chk("t5_reload_addr", bus.oRELOAD_ADDR, 32'h0);
        chk("t5_psr", bus.oPSR, 32'h0);
        chk("t5_idtr", bus.oIDTR, 32'h0);
        chk("t5_pdtr", bus.oPDTR, 32'h0);
        rst        = 1'b0;
        tlb_ack_en = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.oRELOAD_VALID) n++;
        end
        chk("t5_no_reload_after_reset", n, 32'd0);

        // Normal operation after reset
        push_exp(32'h700, 32'h0, 32'h40, 32'h0, 1'b0);
        issue(1'b0, 1'b0, 1'b1, 32'h40, 32'h700);
        wait_idle("t5b", n);

`ifdef SYS_REG_WATCHDOG_EN
        // 6: reload never acked -> watchdog error after 16 cycles
        rel_ack_en = 1'b0;
        push_exp(32'h600, 32'h0, 32'h1234, 32'h0, 1'b0);
        issue(1'b0, 1'b0, 1'b1, 32'h1234, 32'h600);
        n = 0;
        while (!bus.oRELOAD_VALID && (n < 50)) begin
            n++;
            @(negedge clk);
        end
        n = 0;
        while (bus.oRELOAD_VALID && !bus.oERROR && (n < 100)) begin
            n++;
            @(negedge clk);
        end
        chk("t6_reload_cycles", n, 32'd16);
        chk("t6_error", {31'd0, bus.oERROR}, 32'd1);
        chk("t6_busy", {31'd0, bus.oBUSY}, 32'd0);
        chk("t6_idtr_committed", bus.oIDTR, 32'h1234);
        rel_ack_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_error_sticky", {31'd0, bus.oERROR}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_error_cleared", {31'd0, bus.oERROR}, 32'd0);
`else
        chk("error_tied_low", {31'd0, bus.oERROR}, 32'd0);
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
